cache_axi_ctrl: RTL and testbench
=================================

# cache_axi_ctrl

Sequential AXI3 master-port controller that shares one AXI read channel between the instruction cache and data cache, and owns the data cache's write channel. It grants the read channel to one requester per burst, using round-robin priority. It tracks each burst from AR handshake to RLAST and each write from AW handshake to B response. A data-cache read cannot overtake a pending or in-flight data-cache write. It sits between the I/D cache refill/writeback logic and the core's single AXI master interface.

## Interface
- No parameters. Data width is 32, burst length field is 4 bits (AXI3), and IDs are 4 bits.
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- i_araddr/i_arlen/i_arburst  in  32/8/2  I-cache read request fields
- i_arvalid  in  1  I-cache read request valid
- i_arready  out  1  I-cache read request accepted
- i_rdata  out  32  I-cache read data
- i_rlast  out  1  I-cache last beat
- i_rvalid  out  1  I-cache read beat valid
- i_rready  in  1  I-cache accepts read beat
- d_araddr/d_arlen/d_arburst/d_arsize  in  32/8/2/3  D-cache read request fields
- d_arvalid  in  1  D-cache read request valid
- d_arready  out  1  D-cache read request accepted
- d_rdata/d_rlast/d_rvalid  out  32/1/1  D-cache read data, last beat, beat valid
- d_rready  in  1  D-cache accepts read beat
- d_awaddr/d_awlen/d_awburst/d_awsize  in  32/8/2/3  D-cache write address fields
- d_awvalid  in  1  D-cache write address valid
- d_awready  out  1  write address accepted
- d_wdata/d_wstrb/d_wlast/d_wvalid  in  32/4/1/1  D-cache write data
- d_wready  out  1  write beat accepted
- d_bvalid  out  1  write response valid
- d_bready  in  1  D-cache accepts write response
- AXI3 master read address: arid[4], araddr[32], arlen[4], arsize[3], arburst[2], arlock[2], arcache[4], arprot[3], arvalid out; arready in
- AXI3 master read data: rid[4], rdata[32], rresp[2], rlast, rvalid in; rready out
- AXI3 master write address: awid[4], awaddr[32], awlen[4], awsize[3], awburst[2], awlock[2], awcache[4], awprot[3], awvalid out; awready in
- AXI3 master write data: wid[4], wdata[32], wstrb[4], wlast, wvalid out; wready in
- AXI3 master write response: bid[4], bresp[2], bvalid in; bready out

## Operation

**Read FSM (R_IDLE, R_ADDR, R_DATA).** A 1-bit `owner` register records the granted requester (0 = I, 1 = D). A 1-bit `last` register records the previous winner; it resets to 1, so I wins the first tie.
- **R_IDLE:** compute eligibility.
  - I is eligible when i_arvalid = 1.
  - D is eligible when d_arvalid = 1, the write FSM is in W_IDLE, and d_awvalid = 0.
  - If only one requester is eligible, it wins. If both are, the one not equal to `last` wins.
  - On a win: load `owner`, then go to R_ADDR.
- **R_ADDR:** drive the read address channel from the owner's fields.
  - arvalid = 1; arid = {3'b0, owner}; arlen = owner's arlen[3:0].
  - arsize = d_arsize for D, fixed 3'b010 for I.
  - arlock = 0, arcache = 0, arprot = 0.
  - The owner's *_arready = arready; the other requester's arready = 0.
  - On arvalid & arready: set `last` = owner, go to R_DATA.
- **R_DATA:** route the read data channel to the owner.
  - Owner's rdata/rlast/rvalid = bus values; rready = owner's rready.
  - Non-owner's rvalid/rlast = 0 and rdata = 0.
  - rid and rresp are ignored.
  - On rvalid & rready & rlast: go to R_IDLE.
- Exactly one read burst is outstanding at a time.

**Write FSM (W_IDLE, W_ADDR, W_DATA, W_RESP).**
- **W_IDLE:** if d_awvalid = 1, go to W_ADDR.
- **W_ADDR:** awvalid = d_awvalid; d_awready = awready. awid = 0, awlock = 0, awcache = 0, awprot = 0; awlen = d_awlen[3:0]. On the AW handshake, go to W_DATA.
- **W_DATA:** wvalid = d_wvalid; d_wready = wready; wid = 0. On wvalid & wready & wlast, go to W_RESP.
- **W_RESP:** bready = d_bready; d_bvalid = bvalid. On bvalid & bready, go to W_IDLE.
- Write address, data and response signals are gated to 0 outside their own state.

**Ordering.** D reads are blocked from W_ADDR entry (or earlier, from d_awvalid assertion) until the B handshake completes. I reads are never blocked by writes, and read and write bursts may overlap on the bus.

**Reset.** On rst, both FSMs return to idle, `owner` = 0 and `last` = 1. All valid/ready outputs are 0 the cycle after rst is sampled, and data outputs are 0. A burst interrupted mid-flight is not resumed; rst resets the whole system.

## Timing
- Grant latency: request seen in R_IDLE at cycle N gives arvalid at N+1. The minimum read occupancy is 1 (idle) + 1 (AR) + beats cycles.
- Back-to-back reads: after the RLAST handshake at cycle N, the next arvalid appears at N+2.
- Write latency: d_awvalid at N gives awvalid at N+1. The minimum write occupancy is 1 + 1 + beats + 1 cycles.
- The AR, R, AW, W and B paths are combinational muxes of the registered state. There are no combinational paths from a bus ready to a requester valid.
- Requesters hold their request fields stable while valid (AXI rule). The block does not register address fields.

## Test plan
- **Single I read:** i_arvalid with araddr 0x1FC0_0000, i_arlen 7 → arvalid one cycle later with arid 0, arlen 7, arsize 3'b010. Eight beats reach i_rdata; d_rvalid stays 0. Return to R_IDLE after rlast.
- **Simultaneous I and D requests from reset:** I wins first with arid 0. After its rlast, D is granted with arid 1. A second simultaneous request then goes to I (alternation).
- **Write blocks D read:** d_awvalid and d_arvalid asserted together → AW issued, d_arready stays 0 through W_DATA and W_RESP. The D read is granted two cycles after the bvalid & bready cycle.
- **I read during write:** a 4-beat write with wready toggling plus an I read → both complete, wvalid follows d_wvalid only in W_DATA, and I data arrives uncorrupted.
- **Backpressure:** i_rready low for 3 cycles mid-burst → rready low, and the beat is held until i_rready rises.
- **Reset mid-burst:** rst asserted during R_DATA beat 3 → next cycle arvalid, rready, awvalid, wvalid and bready are 0, both FSMs are idle, and the next I request gets arid 0.

Source files
------------

// File: rtl/cache_axi_ctrl.sv
// cache_axi_ctrl
// Puts the instruction and data caches onto one AXI3 master port.
// The read channel is shared by both caches. It is granted one burst at a time
// using round-robin priority. The write channel belongs to the data cache only.
// A data-cache read is never granted while a data-cache write is waiting or in
// flight, so a refill cannot read a line before its writeback lands.
//
// Ports
//   clk, rst                    : clock and synchronous active-high reset
//   i_ar*/i_r*                  : I-cache read request and read data
//   d_ar*/d_r*                  : D-cache read request and read data
//   d_aw*/d_w*/d_b*             : D-cache write address, data and response
//   ar*/r*/aw*/w*/b*            : AXI3 master port toward the interconnect
module cache_axi_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [1:0]  i_arburst,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [1:0]  d_arburst,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [1:0]  d_awburst,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic     owner, owner_next;   // 0 = I-cache, 1 = D-cache
  logic     last, last_next;     // previous winner; reset to 1 so I wins the first tie
  logic     i_elig, d_elig, grant_d;

  // Read responses carry no useful ID or error information for the caches.
  // Only AXI3 lengths are supported, so the upper length bits are dropped.
  logic unused_bits;
  assign unused_bits = ^{rid, rresp, bid, bresp, i_arlen[7:4], d_arlen[7:4], d_awlen[7:4]};

  // The D-cache may read only while no write of its own is pending.
  // Checking d_awvalid as well closes the one-cycle window before W_ADDR.
  assign i_elig  = i_arvalid;
  assign d_elig  = d_arvalid && (w_state == W_IDLE) && !d_awvalid;
  assign grant_d = d_elig && (!i_elig || !last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
    end else begin
      r_state <= r_next;
      owner   <= owner_next;
      last    <= last_next;
    end
  end

  always_comb begin
    r_next     = r_state;
    owner_next = owner;
    last_next  = last;
    case (r_state)
      R_IDLE: begin
        if (i_elig || d_elig) begin
          owner_next = grant_d;
          r_next     = R_ADDR;
        end
      end
      R_ADDR: begin
        if (arready) begin
          last_next = owner;
          r_next    = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid && rlast && (owner ? d_rready : i_rready)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arid      = 4'd0;
    araddr    = 32'd0;
    arlen     = 4'd0;
    arsize    = 3'd0;
    arburst   = 2'd0;
    arlock    = 2'd0;
    arcache   = 4'd0;
    arprot    = 3'd0;
    arvalid   = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    rready    = 1'b0;
    i_rdata   = 32'd0;
    i_rlast   = 1'b0;
    i_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    d_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    case (r_state)
      R_ADDR: begin
        arvalid   = 1'b1;
        arid      = {3'b000, owner};
        araddr    = owner ? d_araddr : i_araddr;
        arlen     = owner ? d_arlen[3:0] : i_arlen[3:0];
        arsize    = owner ? d_arsize : 3'b010;
        arburst   = owner ? d_arburst : i_arburst;
        i_arready = !owner && arready;
        d_arready = owner && arready;
      end
      R_DATA: begin
        rready = owner ? d_rready : i_rready;
        if (owner) begin
          d_rdata  = rdata;
          d_rlast  = rlast;
          d_rvalid = rvalid;
        end else begin
          i_rdata  = rdata;
          i_rlast  = rlast;
          i_rvalid = rvalid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (d_awvalid) w_next = W_ADDR;
      W_ADDR: if (d_awvalid && awready) w_next = W_DATA;
      W_DATA: if (d_wvalid && wready && d_wlast) w_next = W_RESP;
      W_RESP: if (bvalid && d_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Each write channel is passed through only in its own phase, so an early
  // W beat or a late B handshake from the cache cannot leak onto the bus.
  always_comb begin
    awid      = 4'd0;
    awaddr    = 32'd0;
    awlen     = 4'd0;
    awsize    = 3'd0;
    awburst   = 2'd0;
    awlock    = 2'd0;
    awcache   = 4'd0;
    awprot    = 3'd0;
    awvalid   = 1'b0;
    d_awready = 1'b0;
    wid       = 4'd0;
    wdata     = 32'd0;
    wstrb     = 4'd0;
    wlast     = 1'b0;
    wvalid    = 1'b0;
    d_wready  = 1'b0;
    bready    = 1'b0;
    d_bvalid  = 1'b0;
    case (w_state)
      W_ADDR: begin
        awvalid   = d_awvalid;
        awaddr    = d_awaddr;
        awlen     = d_awlen[3:0];
        awsize    = d_awsize;
        awburst   = d_awburst;
        d_awready = awready;
      end
      W_DATA: begin
        wvalid   = d_wvalid;
        wdata    = d_wdata;
        wstrb    = d_wstrb;
        wlast    = d_wlast;
        d_wready = wready;
      end
      W_RESP: begin
        bready   = d_bready;
        d_bvalid = bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_axi_ctrl.sv
// tb_cache_axi_ctrl
// Directed scenarios with randomized addresses, lengths, data and handshake
// delays for cache_axi_ctrl. The bench plays both caches and the AXI slave in
// lockstep. It predicts read grants from the round-robin rule and checks every
// routed field against the values it drove.
module tb_cache_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic [1:0]  i_arburst;
  logic        i_arvalid, i_arready;
  logic [31:0] i_rdata;
  logic        i_rlast, i_rvalid, i_rready;
  logic [31:0] d_araddr;
  logic [7:0]  d_arlen;
  logic [1:0]  d_arburst;
  logic [2:0]  d_arsize;
  logic        d_arvalid, d_arready;
  logic [31:0] d_rdata;
  logic        d_rlast, d_rvalid, d_rready;
  logic [31:0] d_awaddr;
  logic [7:0]  d_awlen;
  logic [1:0]  d_awburst;
  logic [2:0]  d_awsize;
  logic        d_awvalid, d_awready;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int   vectors = 0;
  int   miscompares = 0;
  logic model_last;

  always #5 clk = ~clk;

  cache_axi_ctrl dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arburst(i_arburst),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arburst(d_arburst), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awburst(d_awburst), .d_awsize(d_awsize),
    .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid),
    .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Round-robin rule: a lone requester wins; on a tie the previous loser wins.
  function automatic logic pickWinner(input logic i_req, input logic d_req, input logic prev);
    if (i_req && d_req) return ~prev;
    else if (d_req)     return 1'b1;
    else                return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req_d, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size);
    if (req_d) begin
      d_araddr = addr; d_arlen = len; d_arburst = burst; d_arsize = size; d_arvalid = 1'b1;
    end else begin
      i_araddr = addr; i_arlen = len; i_arburst = burst; i_arvalid = 1'b1;
    end
  endtask

  task automatic startWrite(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
    d_awaddr = addr; d_awlen = len; d_awburst = burst; d_awsize = size; d_awvalid = 1'b1;
  endtask

  // Called in the first AR cycle; returns in the idle cycle after RLAST.
  task automatic serveRead(input logic own, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    int delay;
    logic [31:0] beat;
    logic lst;
    check1("ar_valid", arvalid, 1'b1);
    checkOutput("ar_id", 32'(arid), 32'({3'b000, own}));
    checkOutput("ar_addr", araddr, addr);
    checkOutput("ar_len", 32'(arlen), 32'(len));
    checkOutput("ar_size", 32'(arsize), 32'(size));
    checkOutput("ar_burst", 32'(arburst), 32'(burst));
    checkOutput("ar_attr", 32'({arlock, arcache, arprot}), 32'd0);
    i_rready = 1'b1; d_rready = 1'b1;
    #1;
    check1("r_ready_in_addr", rready, 1'b0);
    i_rready = 1'b0; d_rready = 1'b0;
    delay = int'($urandom_range(0, 2));
    repeat (delay) begin
      arready = 1'b0;
      #1;
      check1("ar_ready_hold", own ? d_arready : i_arready, 1'b0);
      tick();
      check1("ar_valid_hold", arvalid, 1'b1);
    end
    arready = 1'b1;
    #1;
    check1("i_arready_route", i_arready, ~own);
    check1("d_arready_route", d_arready, own);
    tick();
    arready = 1'b0;
    if (own) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      beat = $urandom;
      lst = (k == int'(len));
      rdata = beat; rvalid = 1'b1; rlast = lst;
      rid = 4'($urandom); rresp = 2'($urandom);
      if (k == stall_beat) begin
        if (own) d_rready = 1'b0; else i_rready = 1'b0;
        repeat (3) begin
          #1;
          check1("r_ready_stall", rready, 1'b0);
          check1("r_valid_stall", own ? d_rvalid : i_rvalid, 1'b1);
          checkOutput("r_data_stall", own ? d_rdata : i_rdata, beat);
          tick();
        end
      end
      if (own) d_rready = 1'b1; else i_rready = 1'b1;
      #1;
      check1("r_ready", rready, 1'b1);
      check1("r_valid", own ? d_rvalid : i_rvalid, 1'b1);
      checkOutput("r_data", own ? d_rdata : i_rdata, beat);
      check1("r_last", own ? d_rlast : i_rlast, lst);
      check1("r_other_valid", own ? i_rvalid : d_rvalid, 1'b0);
      check1("r_other_last", own ? i_rlast : d_rlast, 1'b0);
      checkOutput("r_other_data", own ? i_rdata : d_rdata, 32'd0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; i_rready = 1'b0; d_rready = 1'b0;
    #1;
    check1("r_idle_after_last", arvalid, 1'b0);
    check1("r_ready_idle", rready, 1'b0);
  endtask

  // Called in the first AW cycle; returns in the cycle after the B handshake.
  task automatic serveWrite(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic check_d_blocked);
    int delay, sent, cyc;
    check1("aw_valid", awvalid, 1'b1);
    checkOutput("aw_addr", awaddr, addr);
    checkOutput("aw_len", 32'(awlen), 32'(len));
    checkOutput("aw_size", 32'(awsize), 32'(size));
    checkOutput("aw_burst", 32'(awburst), 32'(burst));
    checkOutput("aw_id", 32'(awid), 32'd0);
    checkOutput("aw_attr", 32'({awlock, awcache, awprot}), 32'd0);
    d_wvalid = 1'b1; wready = 1'b1;
    #1;
    check1("w_gated_in_addr", wvalid, 1'b0);
    check1("wready_gated_in_addr", d_wready, 1'b0);
    d_wvalid = 1'b0; wready = 1'b0;
    delay = int'($urandom_range(0, 2));
    repeat (delay) begin
      awready = 1'b0;
      #1;
      check1("aw_ready_wait", d_awready, 1'b0);
      if (check_d_blocked) check1("ar_blocked_waddr", arvalid, 1'b0);
      tick();
    end
    awready = 1'b1;
    #1;
    check1("aw_ready_pass", d_awready, 1'b1);
    tick();
    d_awvalid = 1'b0; awready = 1'b0;
    sent = 0; cyc = 0;
    while (sent <= int'(len) && cyc < 200) begin
      d_wvalid = ($urandom_range(0, 3) != 0);
      d_wdata  = $urandom;
      d_wstrb  = 4'($urandom);
      d_wlast  = (sent == int'(len));
      wready   = (cyc % 2 == 0);
      #1;
      check1("w_valid", wvalid, d_wvalid);
      check1("w_ready", d_wready, wready);
      checkOutput("w_data", wdata, d_wdata);
      checkOutput("w_strb", 32'(wstrb), 32'(d_wstrb));
      check1("w_last", wlast, d_wlast);
      checkOutput("w_id", 32'(wid), 32'd0);
      if (check_d_blocked) begin
        check1("d_arready_blocked_wdata", d_arready, 1'b0);
        check1("ar_blocked_wdata", arvalid, 1'b0);
      end
      if (d_wvalid && wready) sent++;
      tick();
      cyc++;
    end
    d_wvalid = 1'b0; d_wlast = 1'b0; wready = 1'b0;
    checkOutput("w_beats", 32'(sent), 32'(int'(len) + 1));
    d_bready = 1'b1;
    delay = int'($urandom_range(0, 2));
    repeat (delay) begin
      bvalid = 1'b0;
      d_wvalid = 1'b1; wready = 1'b1;
      #1;
      check1("b_ready", bready, 1'b1);
      check1("b_valid_wait", d_bvalid, 1'b0);
      check1("w_gated_in_resp", wvalid, 1'b0);
      if (check_d_blocked) check1("ar_blocked_wresp", arvalid, 1'b0);
      d_wvalid = 1'b0; wready = 1'b0;
      tick();
    end
    bvalid = 1'b1; bresp = 2'($urandom); bid = 4'($urandom);
    #1;
    check1("b_valid", d_bvalid, 1'b1);
    if (check_d_blocked) check1("d_arready_blocked_b", d_arready, 1'b0);
    tick();
    bvalid = 1'b0;
    #1;
    check1("b_ready_idle", bready, 1'b0);
    d_bready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] ia, da, wa;
    logic [7:0]  il, dl;
    logic [1:0]  ib, db, wb;
    logic [2:0]  ds, wsz;
    logic        w;

    rst = 1'b1;
    i_araddr = '0; i_arlen = '0; i_arburst = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arburst = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    d_awaddr = '0; d_awlen = '0; d_awburst = '0; d_awsize = '0; d_awvalid = 1'b0;
    d_wdata = '0; d_wstrb = '0; d_wlast = 1'b0; d_wvalid = 1'b0; d_bready = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    model_last = 1'b1;
    #1;
    $display("[TB] reset state");
    check1("rst_arvalid", arvalid, 1'b0);
    check1("rst_rready", rready, 1'b0);
    check1("rst_awvalid", awvalid, 1'b0);
    check1("rst_wvalid", wvalid, 1'b0);
    check1("rst_bready", bready, 1'b0);
    check1("rst_i_arready", i_arready, 1'b0);
    check1("rst_d_arready", d_arready, 1'b0);
    check1("rst_d_awready", d_awready, 1'b0);
    check1("rst_d_wready", d_wready, 1'b0);
    check1("rst_d_bvalid", d_bvalid, 1'b0);
    check1("rst_i_rvalid", i_rvalid, 1'b0);
    check1("rst_d_rvalid", d_rvalid, 1'b0);
    checkOutput("rst_araddr", araddr, 32'd0);

    $display("[TB] single I read");
    ib = 2'($urandom);
    applyStimulus(1'b0, 32'h1FC0_0000, 8'h07, ib, 3'b000);
    #1;
    check1("grant_latency_idle", arvalid, 1'b0);
    tick();
    w = pickWinner(1'b1, 1'b0, model_last); model_last = w;
    serveRead(w, 32'h1FC0_0000, 4'd7, 3'b010, ib, -1);

    $display("[TB] simultaneous I and D from reset");
    rst = 1'b1; tick(); rst = 1'b0;
    model_last = 1'b1;
    ia = $urandom; il = {4'($urandom), 4'($urandom_range(0, 5))}; ib = 2'($urandom);
    da = $urandom; dl = {4'($urandom), 4'($urandom_range(0, 5))}; db = 2'($urandom); ds = 3'($urandom);
    applyStimulus(1'b0, ia, il, ib, 3'b000);
    applyStimulus(1'b1, da, dl, db, ds);
    tick();
    w = pickWinner(1'b1, 1'b1, model_last); model_last = w;
    serveRead(w, ia, il[3:0], 3'b010, ib, -1);
    tick();
    w = pickWinner(1'b0, 1'b1, model_last); model_last = w;
    serveRead(w, da, dl[3:0], ds, db, -1);
    ia = $urandom; da = $urandom;
    applyStimulus(1'b0, ia, il, ib, 3'b000);
    applyStimulus(1'b1, da, dl, db, ds);
    tick();
    w = pickWinner(1'b1, 1'b1, model_last); model_last = w;
    serveRead(w, ia, il[3:0], 3'b010, ib, -1);
    tick();
    w = pickWinner(1'b0, 1'b1, model_last); model_last = w;
    serveRead(w, da, dl[3:0], ds, db, -1);

    $display("[TB] write blocks D read");
    wa = $urandom; wb = 2'($urandom); wsz = 3'($urandom);
    da = $urandom; dl = 8'h03; db = 2'($urandom); ds = 3'($urandom);
    startWrite(wa, 8'h53, wb, wsz);
    applyStimulus(1'b1, da, dl, db, ds);
    #1;
    check1("aw_latency_idle", awvalid, 1'b0);
    check1("ar_blocked_idle", arvalid, 1'b0);
    tick();
    serveWrite(wa, 4'd3, wsz, wb, 1'b1);
    check1("d_read_held_after_b", arvalid, 1'b0);
    tick();
    w = pickWinner(1'b0, 1'b1, model_last); model_last = w;
    serveRead(w, da, dl[3:0], ds, db, -1);

    $display("[TB] I read during write");
    wa = $urandom; wb = 2'($urandom); wsz = 3'($urandom);
    ia = $urandom; il = 8'h05; ib = 2'($urandom);
    startWrite(wa, 8'h03, wb, wsz);
    applyStimulus(1'b0, ia, il, ib, 3'b000);
    tick();
    w = pickWinner(1'b1, 1'b0, model_last); model_last = w;
    fork
      serveWrite(wa, 4'd3, wsz, wb, 1'b0);
      serveRead(w, ia, il[3:0], 3'b010, ib, -1);
    join

    $display("[TB] read backpressure");
    tick();
    ia = $urandom; il = 8'hA5; ib = 2'($urandom);
    applyStimulus(1'b0, ia, il, ib, 3'b000);
    tick();
    w = pickWinner(1'b1, 1'b0, model_last); model_last = w;
    serveRead(w, ia, il[3:0], 3'b010, ib, 2);

    $display("[TB] reset mid-burst");
    tick();
    wa = $urandom; wb = 2'($urandom); wsz = 3'($urandom);
    startWrite(wa, 8'h07, wb, wsz);
    tick();
    awready = 1'b1;
    tick();
    d_awvalid = 1'b0; awready = 1'b0; d_wvalid = 1'b1; wready = 1'b0;
    ia = $urandom;
    applyStimulus(1'b0, ia, 8'h07, 2'b01, 3'b000);
    tick();
    arready = 1'b1;
    tick();
    i_arvalid = 1'b0; arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdata = $urandom; rvalid = 1'b1; rlast = 1'b0; i_rready = 1'b1;
      #1;
      checkOutput("pre_rst_beat", i_rdata, rdata);
      tick();
    end
    rst = 1'b1; bvalid = 1'b1; d_bready = 1'b1; wready = 1'b1; arready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check1("midrst_arvalid", arvalid, 1'b0);
    check1("midrst_rready", rready, 1'b0);
    check1("midrst_awvalid", awvalid, 1'b0);
    check1("midrst_wvalid", wvalid, 1'b0);
    check1("midrst_bready", bready, 1'b0);
    check1("midrst_i_rvalid", i_rvalid, 1'b0);
    check1("midrst_d_bvalid", d_bvalid, 1'b0);
    check1("midrst_d_wready", d_wready, 1'b0);
    rvalid = 1'b0; rdata = 32'd0; i_rready = 1'b0; d_wvalid = 1'b0; wready = 1'b0;
    bvalid = 1'b0; d_bready = 1'b0; arready = 1'b0;
    model_last = 1'b1;
    ia = $urandom; il = 8'h02; ib = 2'($urandom);
    da = $urandom; dl = 8'h01; db = 2'($urandom); ds = 3'($urandom);
    applyStimulus(1'b0, ia, il, ib, 3'b000);
    applyStimulus(1'b1, da, dl, db, ds);
    tick();
    w = pickWinner(1'b1, 1'b1, model_last); model_last = w;
    serveRead(w, ia, il[3:0], 3'b010, ib, -1);
    tick();
    w = pickWinner(1'b0, 1'b1, model_last); model_last = w;
    serveRead(w, da, dl[3:0], ds, db, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
